// File: rtl/i2s_pkg.sv
// Shared I2S definitions: stream/channel widths, receiver FSM encoding and
// the stereo frame packing used by both the receiver and the transmitter.
package i2s_pkg;

  localparam int AXIS_DATA_W = 64;
  localparam int CH_W        = 32;

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } state_t;

  // Left channel occupies the upper half, right channel the lower half.
  function automatic logic [AXIS_DATA_W-1:0] pack_frame(input logic [CH_W-1:0] left,
                                                        input logic [CH_W-1:0] right);
    return {left, right};
  endfunction

endpackage

// File: rtl/i2s_in_sync.sv
// Brings the asynchronous I2S pins into the aclk domain. All three pins run
// through identical-depth chains so the sampled lrck/sdin line up with the
// sclk rise strobe.
module i2s_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic aclk,
  input  logic resetn,
  input  logic sclk_i,
  input  logic lrck_i,
  input  logic sdin_i,
  output logic rise_o,
  output logic lrck_o,
  output logic sdin_o
);

  logic [SYNC_STAGES-1:0] sclk_q;
  logic [SYNC_STAGES-1:0] lrck_q;
  logic [SYNC_STAGES-1:0] sdin_q;
  logic                   sclk_prev_q;

  // Synchroniser chains plus one extra sclk flop for edge detection.
  always_ff @(posedge aclk) begin
    if (!resetn) begin
      sclk_q      <= '0;
      lrck_q      <= '0;
      sdin_q      <= '0;
      sclk_prev_q <= 1'b0;
    end else begin
      sclk_q      <= {sclk_q[SYNC_STAGES-2:0], sclk_i};
      lrck_q      <= {lrck_q[SYNC_STAGES-2:0], lrck_i};
      sdin_q      <= {sdin_q[SYNC_STAGES-2:0], sdin_i};
      sclk_prev_q <= sclk_q[SYNC_STAGES-1];
    end
  end

  assign rise_o = sclk_q[SYNC_STAGES-1] & ~sclk_prev_q;
  assign lrck_o = lrck_q[SYNC_STAGES-1];
  assign sdin_o = sdin_q[SYNC_STAGES-1];

endmodule

// File: rtl/axis_i2s_rx.sv
// I2S slave receiver. Deserialises left/right words from oversampled pins and
// presents one stereo frame per LRCK period on an AXI4-Stream master.
//
//  state | meaning
//  SYNC  | waiting for a left slot start, data ignored
//  LEFT  | collecting left word
//  RIGHT | collecting right word, frame emitted on its last data bit
module axis_i2s_rx
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH  = 24,
  parameter int SLOT_WIDTH  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   aclk,
  input  logic                   resetn,
  input  logic                   i2s_sclk,
  input  logic                   i2s_lrck,
  input  logic                   i2s_sdin,
  output logic [AXIS_DATA_W-1:0] m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic                   overflow,
  output logic                   frame_err
);

  localparam int CNT_W = $clog2(SLOT_WIDTH + 1);
  localparam logic [CNT_W-1:0] DW_CNT   = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] SLOT_CNT = CNT_W'(SLOT_WIDTH);

  logic rise, lrck_s, sdin_s;

  i2s_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .aclk   (aclk),
    .resetn (resetn),
    .sclk_i (i2s_sclk),
    .lrck_i (i2s_lrck),
    .sdin_i (i2s_sdin),
    .rise_o (rise),
    .lrck_o (lrck_s),
    .sdin_o (sdin_s)
  );

  state_t                   state_q, state_d;
  logic                     lrck_prev_q;
  logic [CNT_W-1:0]         bit_cnt_q;
  // Holds all but the newest bit; the final bit joins combinationally in word_full.
  logic [DATA_WIDTH-2:0]    shift_q;
  logic [DATA_WIDTH-1:0]    left_hold_q;
  logic [AXIS_DATA_W-1:0]   tdata_q;
  logic                     tvalid_q;
  logic                     overflow_q;
  logic                     frame_err_q;

  logic                     slot_start;
  logic                     last_bit;
  logic [DATA_WIDTH-1:0]    word_full;
  logic                     frame_done;
  logic                     latch_left;
  logic                     short_slot;
  logic [CH_W-1:0]          left_j, right_j;

  assign slot_start = rise & (lrck_s != lrck_prev_q);
  assign last_bit   = rise & ~slot_start & (bit_cnt_q == LAST_CNT);
  assign word_full  = {shift_q, sdin_s};
  assign left_j     = CH_W'(left_hold_q) << (CH_W - DATA_WIDTH);
  assign right_j    = CH_W'(word_full) << (CH_W - DATA_WIDTH);

  // State register.
  always_ff @(posedge aclk) begin
    if (!resetn) state_q <= ST_SYNC;
    else         state_q <= state_d;
  end

  // Slot tracking: next state, left latch, frame completion, short-slot detection.
  always_comb begin
    state_d    = state_q;
    frame_done = 1'b0;
    latch_left = 1'b0;
    short_slot = 1'b0;
    case (state_q)
      ST_SYNC: begin
        if (slot_start && !lrck_s) state_d = ST_LEFT;
      end
      ST_LEFT: begin
        if (slot_start) begin
          if (bit_cnt_q < DW_CNT) begin
            short_slot = 1'b1;
            state_d    = ST_SYNC;
          end else if (lrck_s) begin
            state_d = ST_RIGHT;
          end
        end else if (last_bit) begin
          latch_left = 1'b1;
        end
      end
      ST_RIGHT: begin
        if (slot_start) begin
          if (bit_cnt_q < DW_CNT) begin
            short_slot = 1'b1;
            state_d    = ST_SYNC;
          end else if (!lrck_s) begin
            state_d = ST_LEFT;
          end
        end else if (last_bit) begin
          frame_done = 1'b1;
        end
      end
      default: state_d = ST_SYNC;
    endcase
  end

  // Bit counter and deserialiser; the delay bit at a slot start is dropped.
  always_ff @(posedge aclk) begin
    if (!resetn) begin
      lrck_prev_q <= 1'b0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      left_hold_q <= '0;
    end else begin
      if (rise) begin
        lrck_prev_q <= lrck_s;
        if (slot_start) begin
          bit_cnt_q <= '0;
          shift_q   <= '0;
        end else if (bit_cnt_q < DW_CNT) begin
          shift_q   <= word_full[DATA_WIDTH-2:0];
          bit_cnt_q <= bit_cnt_q + 1'b1;
        end else if (bit_cnt_q < SLOT_CNT) begin
          bit_cnt_q <= bit_cnt_q + 1'b1;
        end
      end
      if (latch_left) left_hold_q <= word_full;
    end
  end

  // Output register: load when free or draining this cycle, otherwise drop and flag.
  always_ff @(posedge aclk) begin
    if (!resetn) begin
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= short_slot;
      if (frame_done) begin
        if (!tvalid_q || m_axis_tready) begin
          tdata_q  <= pack_frame(left_j, right_j);
          tvalid_q <= 1'b1;
        end else begin
          overflow_q <= 1'b1;
        end
      end else if (tvalid_q && m_axis_tready) begin
        tvalid_q <= 1'b0;
      end
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tvalid_q;
  assign overflow      = overflow_q;
  assign frame_err     = frame_err_q;

endmodule
